// File: rtl/fetch_stage.sv
// Instruction fetch: PC register driving combinational imem, 1-cycle IF/ID latency; stall holds PC and IF/ID,
// redirect flushes IF/ID with a bubble and wins over stall. FETCH_PERF_EN builds fetch/stall counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] address,
   input  logic [31:0] instruction,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign address  = pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= {redirect_target[31:2], 2'b00};
      end else if (!stall) begin
         pc <= pc_plus4;
      end
   end

   // A redirect flushes even when stalled so no wrong-path word survives.
   always_ff @(posedge clk) begin
      if (!rst_n || redirect) begin
         if_id_instruction <= NOP_WORD;
         if_id_pc          <= 32'd0;
         if_id_pc_plus4    <= 32'd0;
         if_id_valid       <= 1'b0;
      end else if (!stall) begin
         if_id_instruction <= instruction;
         if_id_pc          <= pc;
         if_id_pc_plus4    <= pc_plus4;
         if_id_valid       <= 1'b1;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (!redirect && !stall) fetch_cnt <= fetch_cnt + 32'd1;
         if (!redirect && stall)  stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt;
   assign stall_count = stall_cnt;
`else
   assign fetch_count = 32'd0;
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued as each step is driven and popped after the edge.
module tb_fetch_stage;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] address;
   logic [31:0] instruction;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   fetch_stage #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .address(address), .instruction(instruction),
      .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
      .fetch_count(fetch_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Memory image: word[i] = i + 0x100
   assign instruction = {2'b00, address[31:2]} + 32'h100;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        vld;
   } ifid_t;

   ifid_t       q[$];
   ifid_t       m_ifid;
   ifid_t       got;
   logic [31:0] m_pc;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'h100;
   endfunction

   // Drive one cycle's inputs, queue the expected IF/ID, clock, then check.
   task automatic step(input logic rs, input logic st, input logic rd, input logic [31:0] tgt);
      rst_n = rs; stall = st; redirect = rd; redirect_target = tgt;
      if (!rs) begin
         m_ifid = '{NOP, 32'd0, 32'd0, 1'b0};
         m_pc = RPC; m_fetch = 0; m_stall = 0;
      end else if (rd) begin
         m_ifid = '{NOP, 32'd0, 32'd0, 1'b0};
         m_pc = {tgt[31:2], 2'b00};
      end else if (st) begin
         m_stall = m_stall + 1;
      end else begin
         m_ifid = '{word_at(m_pc), m_pc, m_pc + 32'd4, 1'b1};
         m_pc = m_pc + 32'd4;
         m_fetch = m_fetch + 1;
      end
      q.push_back(m_ifid);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("address", address, m_pc);
      chk("if_id_instruction", if_id_instruction, got.ins);
      chk("if_id_pc", if_id_pc, got.pc);
      chk("if_id_pc_plus4", if_id_pc_plus4, got.pc4);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, got.vld});
`ifdef FETCH_PERF_EN
      chk("fetch_count", fetch_count, m_fetch);
      chk("stall_count", stall_count, m_stall);
`else
      chk("fetch_count", fetch_count, 32'd0);
      chk("stall_count", stall_count, 32'd0);
`endif
   endtask

   initial begin
      m_pc = RPC; m_fetch = 0; m_stall = 0;
      m_ifid = '{NOP, 32'd0, 32'd0, 1'b0};
      #1;
      // reset state
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b1, 32'h44);
      // free run from reset: addresses 4, 8, C; IF/ID word[0..2]
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("pc_at_C", address, 32'h0000_000C);
      chk("word2_held", if_id_instruction, 32'h102);
      // stall 3 cycles at 0xC
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("stall_frozen_addr", address, 32'h0000_000C);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("resume_addr", address, 32'h0000_0010);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      // re-reset, run to PC=8, redirect to 0x40
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'h40);
      chk("redirect_addr", address, 32'h0000_0040);
      chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("target_word", if_id_instruction, 32'h110);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      // stall and redirect together, unaligned target
      step(1'b1, 1'b1, 1'b1, 32'h23);
      chk("aligned_target", address, 32'h0000_0020);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      // wrap at top of address space
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("wrap_addr", address, 32'h0000_0000);
      chk("wrap_pc4", if_id_pc_plus4, 32'h0000_0000);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      // reset during a redirect
      step(1'b0, 1'b0, 1'b1, 32'h80);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
